// File: rtl/shift_collect_.sv
// shift_collect_: serial-to-parallel collector for one systolic array output lane.
// Optional drop counter enabled by defining SHIFT_COLLECT_DROP_CNT_EN.
module shift_collect_ #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*W-1:0]         out_data,
  output logic [$clog2(N+1)-1:0] count,
  output logic [7:0]             drop_cnt
);

  localparam int CW = $clog2(N + 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]   state;
  logic [W-1:0] slot [N];

  logic accept;
  logic close;

  // handshake flags come straight from the registered state
  assign in_ready  = (state == FILL);
  assign out_valid = (state == FULL);

  // a vector closes when the last slot fills or a non-empty flush arrives
  assign accept = in_ready && in_valid;
  assign close  = in_ready && flush && (count != '0 || in_valid);

  // pack slots so slot k sits at bits [k*W +: W]
  always_comb begin
    out_data = '0;
    for (int k = 0; k < N; k++) begin
      out_data[k*W +: W] = slot[k];
    end
  end

  // fill state machine, word counter and slot storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      count <= '0;
      for (int k = 0; k < N; k++) begin
        slot[k] <= '0;
      end
    end else begin
      unique case (state)
        FILL: begin
          for (int k = 0; k < N; k++) begin
            if (accept && count == CW'(k)) begin
              slot[k] <= in_data;
            end else if (close && CW'(k) >= count) begin
              slot[k] <= '0;
            end
          end
          if (close) begin
            count <= CW'(N);
            state <= FULL;
          end else if (accept) begin
            count <= count + CW'(1);
            if (count == CW'(N - 1)) begin
              state <= FULL;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            count <= '0;
            state <= FILL;
          end
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

`ifdef SHIFT_COLLECT_DROP_CNT_EN
  logic [7:0] drops;

  // count words offered while full, saturating at 255
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drops <= '0;
    end else if (in_valid && !in_ready && drops != 8'hFF) begin
      drops <= drops + 8'd1;
    end
  end

  assign drop_cnt = drops;
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_shift_collect_.sv
// tb_shift_collect_: vector table, random traffic against a queue model,
// and an asynchronous mid-vector reset sequence.
module tb_shift_collect_;

  localparam int N = 4;
  localparam int W = 16;

`ifdef SHIFT_COLLECT_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = '0;
  logic          in_ready;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_data;
  logic [2:0]    count;
  logic [7:0]    drop_cnt;

  int n_chk = 0;
  int n_fail = 0;

  shift_collect_ #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .count(count),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // behavioural model: a queue of held words plus a full flag
  logic [15:0] mq [$];
  bit          mfull;
  logic [63:0] mvec;
  int          mdrop;

  function automatic void m_reset();
    mq.delete();
    mfull = 1'b0;
    mvec = '0;
    mdrop = 0;
  endfunction

  function automatic void m_step();
    if (!mfull) begin
      if (in_valid) mq.push_back(in_data);
      if (mq.size() == N || (flush && mq.size() > 0)) begin
        mvec = '0;
        foreach (mq[k]) mvec[k*W +: W] = mq[k];
        mfull = 1'b1;
      end
    end else begin
      if (in_valid && mdrop < 255) mdrop++;
      if (out_ready) begin
        mfull = 1'b0;
        mq.delete();
      end
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs are set at negedge; advance one posedge, then return at negedge
  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(mfull));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(!mfull));
    chk({tag, ".count"}, 64'(count), mfull ? 64'(N) : 64'(mq.size()));
    chk({tag, ".drop_cnt"}, 64'(drop_cnt), DROP_EN ? 64'(mdrop) : 64'd0);
    if (mfull) chk({tag, ".out_data"}, out_data, mvec);
  endtask

  typedef struct {
    bit          iv;
    logic [15:0] d;
    bit          fl;
    bit          ordy;
    bit          ov;
    int          cnt;
    logic [63:0] data;
    int          drop;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(bit iv, logic [15:0] d, bit fl, bit ordy,
                              bit ov, int cnt, logic [63:0] data, int drop);
    vec_t v;
    v.iv = iv; v.d = d; v.fl = fl; v.ordy = ordy;
    v.ov = ov; v.cnt = cnt; v.data = data; v.drop = drop;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [63:0] d1;
    d1 = 64'h0044_0033_0022_0011;

    add(1, 16'h0011, 0, 0, 0, 1, '0, 0);
    add(1, 16'h0022, 0, 0, 0, 2, '0, 0);
    add(1, 16'h0033, 0, 0, 0, 3, '0, 0);
    add(1, 16'h0044, 0, 0, 1, 4, d1, 0);
    for (int i = 1; i <= 5; i++) add(1, 16'hAAAA, 0, 0, 1, 4, d1, i);
    add(1, 16'hBBBB, 0, 1, 0, 0, '0, 6);
    add(1, 16'h1234, 0, 0, 0, 1, '0, 6);
    add(0, 16'h0000, 1, 0, 1, 4, 64'h0000_0000_0000_1234, 6);
    add(0, 16'h0000, 0, 1, 0, 0, '0, 6);
    add(1, 16'h0101, 0, 0, 0, 1, '0, 6);
    add(1, 16'h0202, 0, 0, 0, 2, '0, 6);
    add(0, 16'h0000, 1, 0, 1, 4, 64'h0000_0000_0202_0101, 6);
    add(0, 16'h0000, 1, 0, 1, 4, 64'h0000_0000_0202_0101, 6);
    add(0, 16'h0000, 0, 1, 0, 0, '0, 6);
    add(0, 16'h0000, 1, 0, 0, 0, '0, 6);
    add(1, 16'h0101, 0, 0, 0, 1, '0, 6);
    add(1, 16'h0303, 1, 0, 1, 4, 64'h0000_0000_0303_0101, 6);
    add(0, 16'h0000, 0, 1, 0, 0, '0, 6);
    add(1, 16'h5555, 1, 0, 1, 4, 64'h0000_0000_0000_5555, 6);
    add(0, 16'h0000, 0, 1, 0, 0, '0, 6);

    // reset state
    m_reset();
    #2;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.out_data", out_data, 64'd0);
    chk("rst.drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // directed vector table
    foreach (tbl[i]) begin
      in_valid = tbl[i].iv;
      in_data = tbl[i].d;
      flush = tbl[i].fl;
      out_ready = tbl[i].ordy;
      cycle();
      chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("tbl%0d.in_ready", i), 64'(in_ready), 64'(!tbl[i].ov));
      chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d.drop_cnt", i), 64'(drop_cnt),
          DROP_EN ? 64'(tbl[i].drop) : 64'd0);
      if (tbl[i].ov)
        chk($sformatf("tbl%0d.out_data", i), out_data, tbl[i].data);
    end

    // random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(3) != 0);
      in_data = 16'($urandom);
      flush = ($urandom_range(7) == 0);
      out_ready = ($urandom_range(3) == 0);
      cycle();
      chk_model($sformatf("rnd%0d", i));
    end

    // asynchronous reset after three words
    in_valid = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    if (mfull) begin
      out_ready = 1'b1;
      in_valid = 1'b0;
      cycle();
      out_ready = 1'b0;
      in_valid = 1'b1;
    end
    while (mq.size() != 0) begin
      in_valid = 1'b0;
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
    end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h0F00 + 16'(i);
      cycle();
    end
    in_valid = 1'b0;
    chk("pre_arst.count", 64'(count), 64'd3);
    #1;
    rst = 1'b0;
    m_reset();
    #1;
    chk("arst.count", 64'(count), 64'd0);
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.out_data", out_data, 64'd0);
    chk("arst.drop_cnt", 64'(drop_cnt), 64'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 16'h00AB;
    flush = 1'b1;
    cycle();
    in_valid = 1'b0;
    flush = 1'b0;
    chk("post_arst.out_data", out_data, 64'h0000_0000_0000_00AB);
    chk_model("post_arst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_collect_.md
Name: shift_collect_

Overview:
- Serial-to-parallel collector: the receive-side counterpart of the column shift register that feeds the MMU systolic array.
- Accepts one 16-bit word per valid cycle from an array output lane and assembles N words into a parallel vector.
- Presents the vector with a valid/ready handshake to the result writeback logic.
- Word order mirrors the shift-out order: the first word received lands in slot 0.

Parameters:
N, 4, words per vector (N >= 2)
W, 16, word width in bits

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low
in_valid  in  1  in_data holds a word this cycle
in_data  in  W  serial input word
in_ready  out  1  collector can accept a word this cycle
flush  in  1  close a partial vector, zero-padding the remaining slots
out_valid  out  1  out_data holds a complete vector
out_ready  in  1  consumer accepts the vector
out_data  out  N*W  packed vector; slot k at bits [k*W +: W]
count  out  $clog2(N+1)  number of words currently held
drop_cnt  out  8  dropped-word counter (see Optional Feature)

Behaviour:
- Reset (rst low, async): state=FILL, count=0, all out_data slots=0, out_valid=0, drop_cnt=0. in_ready=1 as soon as rst deasserts.
- States: FILL, FULL. in_ready = (state==FILL); out_valid = (state==FULL). Both are decoded from registered state with no combinational path from the inputs.
- Word accept in FILL, when in_valid && in_ready at a posedge:
  - slot[count] <= in_data; count <= count+1.
  - If count was N-1, state <= FULL, with count=N in the same edge.
  - Latency: the last word's edge -> out_valid high in the following cycle.
- Flush in FILL:
  - flush && count>0: all slots >= count (after any same-cycle accept) <= 0; count <= N; state <= FULL.
  - flush && in_valid in the same cycle: the word is accepted into slot[count] first, then the remaining slots are padded.
  - flush with count==0 and no in_valid: ignored, no state change.
  - flush && count==0 && in_valid: accept the word into slot 0, pad slots 1..N-1, go FULL.
- FULL state:
  - out_data is stable and in_ready=0.
  - out_valid && out_ready at a posedge: state <= FILL, count <= 0. out_data keeps its value until overwritten slot by slot.
  - in_valid during FULL is not accepted, including the handshake cycle. Throughput is at most one vector per N+1 cycles.
  - flush in FULL is ignored.
- Slots not yet written in FILL retain stale data. Consumers must use out_data only while out_valid=1.
- Reset mid-vector: partial data is discarded and everything returns to reset values immediately, asynchronously.
- No arithmetic beyond the count increment. count never exceeds N and never wraps.

Optional Feature:
- Macro SHIFT_COLLECT_DROP_CNT_EN.
- Defined:
  - drop_cnt increments by 1 on each posedge where in_valid=1 && in_ready=0 (FULL state).
  - It saturates at 255 and is cleared only by reset.
  - An in_valid that coincides with the out handshake counts as a drop.
- Undefined: drop_cnt is tied to 0 and no counter logic is synthesised.

Test Plan (N=4, W=16):
- Reset then serial fill: in_valid continuous with 0x0011,0x0022,0x0033,0x0044 -> out_valid=1 the cycle after the 4th word; out_data=0x0044_0033_0022_0011; count=4; in_ready=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1, data 0xAAAA -> out_data unchanged, in_ready=0. With the macro, drop_cnt=5. Without the macro, drop_cnt=0.
- Handshake/restart: out_ready=1 for one cycle -> next cycle out_valid=0, count=0, in_ready=1; the next word 0x1234 lands in slot 0.
- Flush partial: accept 0x0101,0x0202, then flush=1 with in_valid=0 -> out_data=0x0000_0000_0202_0101, out_valid=1. Flush at count=0 with in_valid=0 -> no change.
- Flush with a same-cycle word: after 0x0101, assert flush=1 with in_valid=1 and 0x0303 -> out_data=0x0000_0000_0303_0101.
- Async reset mid-vector: after 3 words, pulse rst low between clock edges -> count=0, out_valid=0 and out_data=0 immediately; in_ready=1 after release.
